// File: rtl/byte_lane_serializer_pkg.sv
// Shared datapath definitions for the byte lane serializer.
package byte_lane_serializer_pkg;

   localparam int LANES  = 8;
   localparam int LANE_W = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

   // Number of bytes to emit: 0 means a full word, anything above 8 saturates.
   function automatic logic [3:0] eff_count(input logic [3:0] cnt);
      if (cnt == 4'd0 || cnt > 4'd8) return 4'd8;
      return cnt;
   endfunction

endpackage

// File: rtl/byte_lane_serializer_mux.sv
// 8-to-1 byte multiplexer steered by the serializer lane select.
module mux_8X1_8bit (
   input  logic [7:0] D0,
   input  logic [7:0] D1,
   input  logic [7:0] D2,
   input  logic [7:0] D3,
   input  logic [7:0] D4,
   input  logic [7:0] D5,
   input  logic [7:0] D6,
   input  logic [7:0] D7,
   input  logic [2:0] sel,
   output logic [7:0] Y
);

   // Pure combinational lane select.
   always_comb begin
      Y = D0;
      case (sel)
         3'd0:    Y = D0;
         3'd1:    Y = D1;
         3'd2:    Y = D2;
         3'd3:    Y = D3;
         3'd4:    Y = D4;
         3'd5:    Y = D5;
         3'd6:    Y = D6;
         3'd7:    Y = D7;
         default: Y = D0;
      endcase
   end

endmodule

// File: rtl/byte_lane_serializer.sv
// Narrows a 64-bit word into a byte stream: registers the eight lanes,
// walks the lane select up (or down) and drives the byte mux.
module byte_lane_serializer
   import byte_lane_serializer_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_data,
   input  logic [3:0]              in_count,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANE_W-1:0]       out_byte,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_last
);

   localparam logic [SEL_W-1:0] START_SEL = MSB_FIRST ? SEL_W'(LANES-1) : '0;

   ser_state_t                          r_state;
   ser_state_t                          w_next;
   logic [LANES-1:0][LANE_W-1:0]        r_lane;
   logic [SEL_W-1:0]                    r_sel;
   logic [3:0]                          r_rem;
   logic                                w_accept;
   logic                                w_fire;
   logic                                w_last;

   assign w_last = (r_state == ST_SEND) && (r_rem == 4'd1);

   // State register; reset always returns to IDLE, dropping any partial word.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and handshake decode. in_ready is gated by rst_n so a word
   // offered during a reset cycle is never considered accepted.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_accept  = 1'b0;
      w_fire    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) begin
               w_accept = 1'b1;
               w_next   = ST_SEND;
            end
         end
         ST_SEND: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_fire = 1'b1;
               if (w_last) w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Lane capture, remaining-byte counter and lane select walk.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lane <= '0;
         r_sel  <= START_SEL;
         r_rem  <= '0;
      end else if (w_accept) begin
         r_lane <= in_data;
         r_rem  <= eff_count(in_count);
         r_sel  <= START_SEL;
      end else if (w_fire) begin
         if (w_last) begin
            r_rem <= '0;
            r_sel <= START_SEL;
         end else begin
            r_rem <= r_rem - 4'd1;
            r_sel <= MSB_FIRST ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
         end
      end
   end

   assign out_sel  = r_sel;
   assign out_last = w_last;

   // Byte steering comes only from registered lanes and select.
   mux_8X1_8bit u_mux (
      .D0  (r_lane[0]),
      .D1  (r_lane[1]),
      .D2  (r_lane[2]),
      .D3  (r_lane[3]),
      .D4  (r_lane[4]),
      .D5  (r_lane[5]),
      .D6  (r_lane[6]),
      .D7  (r_lane[7]),
      .sel (r_sel),
      .Y   (out_byte)
   );

endmodule

// File: tb/tb_byte_lane_serializer.sv
// Directed bench: an LSB-first and an MSB-first instance share all inputs.
module tb_byte_lane_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic [3:0]  in_count;
   logic        out_ready;

   logic        in_ready0, out_valid0, out_last0;
   logic [7:0]  out_byte0;
   logic [2:0]  out_sel0;
   logic        in_ready1, out_valid1, out_last1;
   logic [7:0]  out_byte1;
   logic [2:0]  out_sel1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   byte_lane_serializer #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_count(in_count), .out_valid(out_valid0),
      .out_ready(out_ready), .out_byte(out_byte0), .out_sel(out_sel0),
      .out_last(out_last0)
   );

   byte_lane_serializer #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_count(in_count), .out_valid(out_valid1),
      .out_ready(out_ready), .out_byte(out_byte1), .out_sel(out_sel1),
      .out_last(out_last1)
   );

   typedef struct {
      logic [63:0] data;
      logic [3:0]  cnt;
      int          n;
      logic [63:0] exp_lsb;  // byte k = k-th byte emitted by dut0
      logic [63:0] exp_msb;  // byte k = k-th byte emitted by dut1
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
      end
   endtask

   task automatic check_beat(input string tag, input logic [7:0] b0, input logic [2:0] s0,
                             input logic [7:0] b1, input logic [2:0] s1, input logic last);
      chk(tag, "valid0", 32'(out_valid0), 32'd1);
      chk(tag, "byte0",  32'(out_byte0),  32'(b0));
      chk(tag, "sel0",   32'(out_sel0),   32'(s0));
      chk(tag, "last0",  32'(out_last0),  32'(last));
      chk(tag, "valid1", 32'(out_valid1), 32'd1);
      chk(tag, "byte1",  32'(out_byte1),  32'(b1));
      chk(tag, "sel1",   32'(out_sel1),   32'(s1));
      chk(tag, "last1",  32'(out_last1),  32'(last));
   endtask

   task automatic check_idle(input string tag);
      chk(tag, "idle_valid0", 32'(out_valid0), 32'd0);
      chk(tag, "idle_valid1", 32'(out_valid1), 32'd0);
      chk(tag, "idle_ready0", 32'(in_ready0),  32'd1);
      chk(tag, "idle_ready1", 32'(in_ready1),  32'd1);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      logic [63:0] el, em;
      el = v.exp_lsb;
      em = v.exp_msb;
      @(negedge clk);
      chk(tag, "accept_ready0", 32'(in_ready0), 32'd1);
      in_valid = 1'b1; in_data = v.data; in_count = v.cnt; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < v.n; k++) begin
         check_beat(tag, el[8*k +: 8], 3'(k), em[8*k +: 8], 3'(7 - k), (k == v.n - 1));
         @(negedge clk);
      end
      check_idle(tag);
   endtask

   initial begin
      logic [7:0] a_lsb [4];
      logic [7:0] a_msb [4];
      int         eb [7];
      logic       pat [7];
      int         hs;

      a_lsb = '{8'h11, 8'h22, 8'h33, 8'h44};
      a_msb = '{8'h88, 8'h77, 8'h66, 8'h55};
      eb    = '{0, 1, 1, 1, 2, 3, 3};
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      vecs[0] = '{64'h8877665544332211, 4'd8,  8, 64'h8877665544332211, 64'h1122334455667788};
      vecs[1] = '{64'h8877665544332211, 4'd3,  3, 64'h0000000000332211, 64'h0000000000667788};
      vecs[2] = '{64'h0123456789ABCDEF, 4'd0,  8, 64'h0123456789ABCDEF, 64'hEFCDAB8967452301};
      vecs[3] = '{64'hF0E0D0C0B0A09080, 4'd12, 8, 64'hF0E0D0C0B0A09080, 64'h8090A0B0C0D0E0F0};
      vecs[4] = '{64'h55000000000000AA, 4'd1,  1, 64'h00000000000000AA, 64'h0000000000000055};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; out_ready = 1'b0;

      // Reset held two cycles
      repeat (2) @(negedge clk);
      chk("reset", "valid0", 32'(out_valid0), 32'd0);
      chk("reset", "valid1", 32'(out_valid1), 32'd0);
      chk("reset", "ready0", 32'(in_ready0),  32'd0);
      chk("reset", "ready1", 32'(in_ready1),  32'd0);
      chk("reset", "sel0",   32'(out_sel0),   32'd0);
      chk("reset", "sel1",   32'(out_sel1),   32'd7);
      chk("reset", "byte0",  32'(out_byte0),  32'd0);
      chk("reset", "last0",  32'(out_last0),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // Table-driven words
      for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: count 4, out_ready pattern 1,0,0,1,1,0,1
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h8877665544332211; in_count = 4'd4;
      hs = 0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = pat[c];
         check_beat($sformatf("bp%0d", c), a_lsb[eb[c]], 3'(eb[c]),
                    a_msb[eb[c]], 3'(7 - eb[c]), (eb[c] == 3));
         if (out_valid0 && out_ready) hs++;
      end
      @(negedge clk);
      chk("bp", "handshakes", 32'(hs), 32'd4);
      out_ready = 1'b1;
      check_idle("bp_end");

      // New word offered while busy must wait for IDLE
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h8877665544332211; in_count = 4'd4;
      @(negedge clk);
      in_data = 64'hC1B200000000B2A1; in_count = 4'd2;
      for (int k = 0; k < 4; k++) begin
         chk("busy", "ready0", 32'(in_ready0), 32'd0);
         check_beat($sformatf("busy%0d", k), a_lsb[k], 3'(k), a_msb[k], 3'(7 - k), (k == 3));
         @(negedge clk);
      end
      chk("busy", "idle_ready0", 32'(in_ready0), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check_beat("busy_new0", 8'hA1, 3'd0, 8'hC1, 3'd7, 1'b0);
      @(negedge clk);
      check_beat("busy_new1", 8'hB2, 3'd1, 8'hB2, 3'd6, 1'b1);
      @(negedge clk);
      check_idle("busy_end");

      // Reset after the 2nd byte of an 8-byte word
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h8877665544332211; in_count = 4'd8;
      @(negedge clk);
      in_valid = 1'b0;
      check_beat("rst_b0", 8'h11, 3'd0, 8'h88, 3'd7, 1'b0);
      @(negedge clk);
      check_beat("rst_b1", 8'h22, 3'd1, 8'h77, 3'd6, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; in_data = 64'hDEADBEEFCAFEF00D; in_count = 4'd8;
      @(negedge clk);
      chk("midrst", "valid0", 32'(out_valid0), 32'd0);
      chk("midrst", "valid1", 32'(out_valid1), 32'd0);
      chk("midrst", "ready0", 32'(in_ready0),  32'd0);
      chk("midrst", "sel0",   32'(out_sel0),   32'd0);
      chk("midrst", "sel1",   32'(out_sel1),   32'd7);
      chk("midrst", "byte0",  32'(out_byte0),  32'd0);
      chk("midrst", "last0",  32'(out_last0),  32'd0);
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check_idle("midrst_release");
      run_vec("restart", vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
